// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval timer: register map, CTRL bit
// positions and FSM state encoding.
package timer_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned EN       = 0;
    localparam int unsigned PERIODIC = 1;
    localparam int unsigned IE       = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every PRESCALE cycles while
// enabled; held at zero when disabled or cleared.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PW       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            pre <= '0;
        end else if (pre == LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    assign tick = en && (pre == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: CTRL/LOAD/COUNT/STATUS register port, 32-bit
// down-counter sequenced by an IDLE/RUN/DONE FSM, level interrupt on expiry.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PW       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tick
);

    state_t      state;
    logic        ctrl_en;
    logic        ctrl_per;
    logic        ctrl_ie;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        pend_q;

    logic ctrl_wr;
    logic start;
    logic stop;
    logic expire;

    assign ctrl_wr = we && (addr == ADDR_CTRL);
    assign start   = ctrl_wr && wdata[EN];
    assign stop    = ctrl_wr && !wdata[EN];
    assign expire  = (state == ST_RUN) && tick && (count_q == '0);

    timer_prescaler #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_RUN),
        .clr  (start),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ctrl_en  <= 1'b0;
            ctrl_per <= 1'b0;
            ctrl_ie  <= 1'b0;
            load_q   <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            rdata    <= '0;
        end else begin
            if (we && (addr == ADDR_LOAD)) begin
                load_q <= wdata;
            end

            // Expiry set takes priority over a write-1-to-clear in the same cycle.
            if (expire) begin
                pend_q <= 1'b1;
            end else if (we && (addr == ADDR_STATUS) && wdata[0]) begin
                pend_q <= 1'b0;
            end

            if (ctrl_wr) begin
                ctrl_en  <= wdata[EN];
                ctrl_per <= wdata[PERIODIC];
                ctrl_ie  <= wdata[IE];
            end

            // A CTRL write overrides whatever the count/tick path would do.
            if (start) begin
                count_q <= load_q;
                state   <= ST_RUN;
            end else if (stop) begin
                state <= ST_IDLE;
            end else if ((state == ST_RUN) && tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - 32'd1;
                end else if (ctrl_per) begin
                    count_q <= load_q;
                end else begin
                    ctrl_en <= 1'b0;
                    state   <= ST_DONE;
                end
            end

            if (re) begin
                case (addr)
                    ADDR_CTRL:   rdata <= {29'd0, ctrl_ie, ctrl_per, ctrl_en};
                    ADDR_LOAD:   rdata <= load_q;
                    ADDR_COUNT:  rdata <= count_q;
                    ADDR_STATUS: rdata <= {31'd0, pend_q};
                endcase
            end
        end
    end

    assign irq = pend_q & ctrl_ie;

endmodule
